triad_encode: RTL and testbench
===============================

Name: triad_encode

Overview:
- Transmitter side of the comparator triad protocol. It converts a one-hot half-strip hit request for one distrip into the 3-bit serial triad that the comparator drives on a distrip line.
- Used as a loopback/self-test source in the comptest board. One instance per distrip feeds the existing triad_decode receivers, so the decode path can be exercised without an analog pulse.
- Enforces a programmable dead time between triads and counts requests it drops.

Parameters:
CNT_W, 8, width of the saturating dropped-request counter
DEAD_W, 4, width of the dead_time control

Ports:
clock  in  1  logic clock (40 MHz domain)
reset  in  1  asynchronous, active-low reset
enable  in  1  when low, new requests are refused; a triad in flight completes
req  in  1  request strobe, sampled on the rising edge of clock
h_strip  in  4  half-strip hit pattern for this distrip; index = {strip_sel, hs_lr}
dead_time  in  DEAD_W  number of idle cycles forced after each triad's last bit
triad  out  1  serial triad output to distrip line
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse in the cycle triad carries the last (hs_lr) bit
multi_hit  out  1  one-cycle pulse: an accepted request had more than one h_strip bit set
drop_cnt  out  CNT_W  count of dropped requests
drop_cnt_rst  in  1  synchronous clear of drop_cnt

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; triad=0, busy=0, done=0, multi_hit=0, drop_cnt=0. Holds regardless of clock. Reset during a triad aborts it immediately, with no partial bits after release.
- States: IDLE, START, STRIP, HSTRIP, DEAD. All outputs are registered.
- Accept condition: req & enable & (state==IDLE) & (h_strip!=0).
  - req with h_strip==0 is ignored; it produces no output and is not counted as a drop.
- Priority: the lowest set h_strip bit wins; its 2-bit index is latched as {s,h}.
  - multi_hit pulses in the cycle after acceptance if popcount(h_strip)>1.
- Timing, with acceptance at edge N:
  - START from N+1: triad=1 (start bit).
  - STRIP from N+2: triad=s.
  - HSTRIP from N+3: triad=h, done=1.
  - After HSTRIP:
    - If dead_time==0, go to IDLE at N+4. The earliest next accept is at edge N+4, so the next start bit appears at N+5.
    - Else go to DEAD for exactly dead_time cycles with triad=0, then IDLE.
- dead_time is sampled when DEAD is entered. Changing it mid-DEAD does not affect the current count.
- In IDLE and DEAD, triad=0.
- busy is registered-state based, so a req is refused in any cycle where state!=IDLE, including the last DEAD cycle.
- Drop rule: a request with req=1, h_strip!=0 and (state!=IDLE or enable=0) increments drop_cnt.
  - drop_cnt saturates at all-ones and does not wrap.
  - drop_cnt_rst has priority over a simultaneous increment; the result is 0.
- enable falling mid-triad: the current triad and DEAD complete normally, then the block stays in IDLE.
- Decoder compatibility: triad_decode driven by this triad stream must reproduce h_strip[index] one-hot.

Decomposition:
- Shared package:
  - State enum (IDLE, START, STRIP, HSTRIP, DEAD).
  - Constant TRIAD_LEN=3.
  - Default CNT_W and DEAD_W values.
- One sub-module, hs_prienc: 4-bit lowest-index priority encoder. Outputs index[1:0], any, multi. Purely combinational.
- The FSM, dead counter and drop counter live in triad_encode.

Test Plan:
- Reset then req, h_strip=4'b0100, dead_time=0 -> triad 1,1,0 on N+1..N+3; done at N+3; busy falls at N+4; multi_hit=0.
- req, h_strip=4'b1010 -> index 1 chosen; triad 1,0,1; multi_hit=1 for one cycle.
- dead_time=3: two reqs held continuously -> second start bit at N+8.
  - Each refused busy-cycle req increments drop_cnt: 6 drops (N+1..N+6). The 7th cycle, N+7, accepts.
- Saturation and clear:
  - 300 reqs with CNT_W=8, enable=0 -> drop_cnt=255 and no triad activity.
  - drop_cnt_rst asserted with a simultaneous drop -> drop_cnt=0.
- Async reset:
  - Assert reset in the STRIP cycle -> triad=0, busy=0 immediately.
  - After release, no residual bits; a fresh req gives a clean triad.
- Loopback: all 4 indices, random dead_time 0..15, into triad_decode (persist=1) -> decoded h_strip equals the requested one-hot every time.

Source files
------------

// File: rtl/triad_encode_pkg.sv
// Shared types and constants for the comparator triad transmitter.
// Imported by the interface, the priority encoder and the top.
package triad_encode_pkg;

    localparam int TRIAD_LEN  = 3;
    localparam int HS_W       = 4;
    localparam int CNT_W_DEF  = 8;
    localparam int DEAD_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STRIP,
        HSTRIP,
        DEAD
    } state_e;

endpackage

// File: rtl/triad_encode_if.sv
// Request/serial-output bundle between a hit source and the triad transmitter.
interface triad_encode_if;
    import triad_encode_pkg::*;

    logic            req;
    logic [HS_W-1:0] h_strip;
    logic            triad;
    logic            busy;
    logic            done;
    logic            multi_hit;

    modport master (
        output req, h_strip,
        input  triad, busy, done, multi_hit
    );

    modport slave (
        input  req, h_strip,
        output triad, busy, done, multi_hit
    );

endinterface

// File: rtl/triad_encode_hs_prienc.sv
// Lowest-index-wins priority encoder over the half-strip hit pattern.
module hs_prienc
    import triad_encode_pkg::*;
(
    input  logic [HS_W-1:0] hs,
    output logic [1:0]      index,
    output logic            any,
    output logic            multi
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        index = '0;
        // Scan downward so the lowest set bit is the last to write index.
        for (int i = HS_W - 1; i >= 0; i--) begin
            if (hs[i]) index = 2'(i);
        end
    end

    assign any   = |hs;
    assign multi = (hs & (hs - HS_W'(1))) != '0;

endmodule

// File: rtl/triad_encode.sv
// Comparator triad transmitter: one-hot half-strip request in, 3-bit serial triad out,
// with programmable post-triad dead time and a saturating dropped-request counter.
module triad_encode
    import triad_encode_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEAD_W = DEAD_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DEAD_W-1:0] dead_time,
    input  logic              drop_cnt_rst,
    output logic [CNT_W-1:0]  drop_cnt,
    triad_encode_if.slave     bus
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              triad_q, triad_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              multi_q, multi_d;

    logic [1:0] hs_idx;
    logic       hs_any;
    logic       hs_multi;
    logic       req_valid;
    logic       accept;

    hs_prienc u_prienc (
        .hs    (bus.h_strip),
        .index (hs_idx),
        .any   (hs_any),
        .multi (hs_multi)
    );

    // An all-zero pattern is not a request at all: neither accepted nor dropped.
    assign req_valid = bus.req && hs_any;
    assign accept    = req_valid && enable && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dead_cnt_d = dead_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    idx_d   = hs_idx;
                end
            end
            START:  state_d = STRIP;
            STRIP:  state_d = HSTRIP;
            HSTRIP: begin
                // dead_time is captured here so later changes cannot stretch this gap.
                if (dead_time == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d    = DEAD;
                    dead_cnt_d = dead_time;
                end
            end
            DEAD: begin
                if (dead_cnt_q <= DEAD_W'(1)) state_d = IDLE;
                else                          dead_cnt_d = dead_cnt_q - DEAD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they land in the same cycle as the state.
    always_comb begin
        triad_d = 1'b0;
        unique case (state_d)
            START:   triad_d = 1'b1;
            STRIP:   triad_d = idx_d[1];
            HSTRIP:  triad_d = idx_d[0];
            default: triad_d = 1'b0;
        endcase
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == HSTRIP);
        multi_d = accept && hs_multi;
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_cnt_rst) begin
            drop_cnt_d = '0;
        end else if (req_valid && !accept && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears
    // every flop so an aborted triad leaves no residual bits on the line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            dead_cnt_q <= '0;
            drop_cnt_q <= '0;
            triad_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dead_cnt_q <= dead_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            triad_q    <= triad_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            multi_q    <= multi_d;
        end
    end

    assign bus.triad     = triad_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.multi_hit = multi_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_triad_encode.sv
// Self-checking bench for triad_encode: directed cases, random traffic against a
// timeline reference model, and a serial triad receiver that decodes the line.
module tb_triad_encode;
    import triad_encode_pkg::*;

    localparam int CNT_W  = 8;
    localparam int DEAD_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [DEAD_W-1:0] dead_time = '0;
    logic              drop_cnt_rst = 1'b0;
    logic [CNT_W-1:0]  drop_cnt;

    triad_encode_if bus_if ();

    triad_encode #(.CNT_W(CNT_W), .DEAD_W(DEAD_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .dead_time    (dead_time),
        .drop_cnt_rst (drop_cnt_rst),
        .drop_cnt     (drop_cnt),
        .bus          (bus_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: times are posedge numbers since the start of the run.
    longint cyc = 0;
    bit     act = 0;
    longint acc_at = 0;
    longint free_at = 0;
    int     m_idx = 0;
    bit     m_multi = 0;
    int     m_drop = 0;
    int     q_exp[$];
    int     dec_phase = 0;
    bit     dec_s = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] hs);
        for (int i = 0; i < 4; i++) if (hs[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        act = 0;
        free_at = 0;
        m_drop = 0;
        q_exp.delete();
        dec_phase = 0;
    endtask

    task automatic model_edge(input bit req, input logic [3:0] hs, input bit en,
                              input logic [3:0] dt, input bit drst);
        bit drop_inc;
        drop_inc = 0;
        if (act && cyc == acc_at + 3) free_at = acc_at + 4 + longint'(dt);
        if (req && hs != 4'd0) begin
            if (en && cyc >= free_at) begin
                act     = 1;
                acc_at  = cyc;
                free_at = cyc + 4;
                m_idx   = lowest(hs);
                m_multi = ($countones(hs) > 1);
                q_exp.push_back(1 << m_idx);
            end else begin
                drop_inc = 1;
            end
        end
        if (drst) m_drop = 0;
        else if (drop_inc && m_drop < CNT_MAX) m_drop++;
    endtask

    task automatic compare();
        longint o;
        bit in_triad;
        bit e_triad;
        int got_hot;
        o = cyc - acc_at;
        in_triad = act && (o <= 2);
        e_triad = 0;
        if (in_triad) e_triad = (o == 0) ? 1'b1 : (o == 1) ? m_idx[1] : m_idx[0];
        check("triad", bus_if.triad, e_triad);
        check("busy", bus_if.busy, act && (cyc < free_at - 1));
        check("done", bus_if.done, in_triad && (o == 2));
        check("multi_hit", bus_if.multi_hit, in_triad && (o == 0) && m_multi);
        check("drop_cnt", drop_cnt, m_drop);
        // Receiver: start bit, strip bit, half-strip bit -> one-hot.
        case (dec_phase)
            0: if (bus_if.triad) dec_phase = 1;
            1: begin dec_s = bus_if.triad; dec_phase = 2; end
            default: begin
                got_hot = 1 << {dec_s, bus_if.triad};
                if (q_exp.size() == 0) check("loopback_unexpected", got_hot, 0);
                else check("loopback", got_hot, q_exp.pop_front());
                dec_phase = 0;
            end
        endcase
    endtask

    task automatic step(input bit req, input logic [3:0] hs, input bit en,
                        input logic [3:0] dt, input bit drst);
        bus_if.req     = req;
        bus_if.h_strip = hs;
        enable         = en;
        dead_time      = dt;
        drop_cnt_rst   = drst;
        @(posedge clock);
        cyc++;
        model_edge(req, hs, en, dt, drst);
        @(negedge clock);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 1, 4'd0, 0);
    endtask

    initial begin
        logic [2:0] bits;
        logic [3:0] hs;

        bus_if.req = 0;
        bus_if.h_strip = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_triad", bus_if.triad, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_multi", bus_if.multi_hit, 0);
        check("rst_drop", drop_cnt, 0);
        reset = 1'b1;
        model_reset();
        idle(2);

        // Single one-hot request, no dead time.
        step(1, 4'b0100, 1, 4'd0, 0);
        bits[2] = bus_if.triad;
        check("t1_multi", bus_if.multi_hit, 0);
        idle(1); bits[1] = bus_if.triad;
        idle(1); bits[0] = bus_if.triad;
        check("t1_done", bus_if.done, 1);
        check("t1_bits", bits, 3'b110);
        idle(1);
        check("t1_busy_fall", bus_if.busy, 0);

        // Two bits set: lowest index (1) wins and multi_hit pulses once.
        step(1, 4'b1010, 1, 4'd0, 0);
        bits[2] = bus_if.triad;
        check("t2_multi", bus_if.multi_hit, 1);
        idle(1); bits[1] = bus_if.triad;
        check("t2_multi_clear", bus_if.multi_hit, 0);
        idle(1); bits[0] = bus_if.triad;
        check("t2_bits", bits, 3'b101);
        idle(2);

        // Held request with dead_time=3: six drops, accept on the eighth edge.
        step(0, 4'd0, 1, 4'd3, 1);
        for (int i = 0; i < 8; i++) step(1, 4'b0001, 1, 4'd3, 0);
        check("t3_second_start", bus_if.triad, 1);
        check("t3_drops", drop_cnt, 6);
        idle(10);

        // Saturation with enable low, then clear beating a simultaneous drop.
        for (int i = 0; i < 300; i++) begin
            hs = 4'($urandom_range(1, 15));
            step(1, hs, 0, 4'd0, 0);
        end
        check("sat_drop", drop_cnt, 255);
        step(1, 4'b0001, 0, 4'd0, 1);
        check("clr_drop", drop_cnt, 0);
        idle(2);

        // Async reset during the STRIP cycle.
        step(1, 4'b1000, 1, 4'd0, 0);
        idle(1);
        check("ar_strip_bit", bus_if.triad, 1);
        reset = 1'b0;
        #1;
        check("ar_triad", bus_if.triad, 0);
        check("ar_busy", bus_if.busy, 0);
        check("ar_done", bus_if.done, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("ar_hold_triad", bus_if.triad, 0);
        check("ar_hold_busy", bus_if.busy, 0);
        reset = 1'b1;
        model_reset();
        idle(4);
        step(1, 4'b0001, 1, 4'd0, 0);
        bits[2] = bus_if.triad;
        idle(1); bits[1] = bus_if.triad;
        idle(1); bits[0] = bus_if.triad;
        check("ar_fresh_bits", bits, 3'b100);
        idle(2);

        // Loopback across all indices with random dead time.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                step(1, 4'(1 << i), 1, 4'($urandom_range(0, 15)), 0);
                for (int w = 0; w < 24 && cyc < free_at; w++)
                    step(0, 4'd0, 1, 4'($urandom_range(0, 15)), 0);
            end
        end

        // Random traffic, including mid-DEAD dead_time changes and enable drops.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 40,
                 ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                 $urandom_range(0, 9) != 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 49) == 0);
        end
        idle(24);
        check("loopback_drained", q_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
